// File: rtl/water_flow_monitor.sv
// water_flow_monitor: watches drum level progress while the controller fills
// or drains. A window counts as bad when the level has not moved at least
// MIN_DELTA in the commanded direction. STRIKE_LIMIT consecutive bad windows
// latch water_flow_error until water_flow_reset is asserted.
module water_flow_monitor #(
   parameter int WINDOW_CYCLES = 16,
   parameter int MIN_DELTA     = 2,
   parameter int STRIKE_LIMIT  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       water_flow_reset,
   input  logic       water_flow_mode,
   input  logic [9:0] water_level_sensor,
   output logic       water_flow_error,
   output logic       monitor_active,
   output logic [3:0] strike_count
);

   localparam int             WCW      = $clog2(WINDOW_CYCLES);
   localparam logic [WCW-1:0] WIN_LOAD = WCW'(WINDOW_CYCLES - 1);
   localparam logic [10:0]    DELTA    = 11'(MIN_DELTA);
   localparam logic [3:0]     LIMIT    = 4'(STRIKE_LIMIT);

   typedef enum logic [1:0] {IDLE, MONITOR, FAULT} state_t;

   state_t         r_state;
   logic [9:0]     r_baseline;
   logic           r_mode_q;
   logic [WCW-1:0] r_win_cnt;
   logic [3:0]     r_strike;
   logic           r_error;
   logic           r_active;

   logic           w_good;
   logic [3:0]     w_strike_inc;

   // Window verdict: compares are done at 11 bits so baseline + delta never wraps.
   // A pinned-full (fill) or empty (drain) level cannot move further and is good.
   function automatic logic window_good(input logic       fill,
                                        input logic [9:0] base,
                                        input logic [9:0] level);
      logic ok;
      if (fill)
         ok = ({1'b0, level} >= ({1'b0, base} + DELTA)) || (level == 10'd1023);
      else
         ok = ({1'b0, base} >= ({1'b0, level} + DELTA)) || (level == 10'd0);
      return ok;
   endfunction

   assign w_good       = window_good(r_mode_q, r_baseline, water_level_sensor);
   assign w_strike_inc = r_strike + 4'd1;

   // Supervision FSM: arm, count windows, score them, latch the fault.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_baseline <= '0;
         r_mode_q   <= 1'b0;
         r_win_cnt  <= '0;
         r_strike   <= '0;
         r_error    <= 1'b0;
         r_active   <= 1'b0;
      end else if (water_flow_reset) begin
         r_state  <= IDLE;
         r_strike <= '0;
         r_error  <= 1'b0;
         r_active <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_baseline <= water_level_sensor;
               r_mode_q   <= water_flow_mode;
               r_win_cnt  <= WIN_LOAD;
               r_strike   <= '0;
               r_state    <= MONITOR;
               r_active   <= 1'b1;
            end
            MONITOR: begin
               if (water_flow_mode != r_mode_q) begin
                  // Direction change: discard the current window and start over.
                  r_baseline <= water_level_sensor;
                  r_mode_q   <= water_flow_mode;
                  r_win_cnt  <= WIN_LOAD;
                  r_strike   <= '0;
               end else if (r_win_cnt != '0) begin
                  r_win_cnt <= r_win_cnt - 1'b1;
               end else if (!w_good && (w_strike_inc == LIMIT)) begin
                  r_strike <= w_strike_inc;
                  r_error  <= 1'b1;
                  r_active <= 1'b0;
                  r_state  <= FAULT;
               end else begin
                  r_strike   <= w_good ? 4'd0 : w_strike_inc;
                  r_baseline <= water_level_sensor;
                  r_win_cnt  <= WIN_LOAD;
               end
            end
            FAULT: begin
               r_error <= 1'b1;
            end
            default: begin
               r_state  <= IDLE;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   assign water_flow_error = r_error;
   assign monitor_active   = r_active;
   assign strike_count     = r_strike;

endmodule

// File: tb/tb_water_flow_monitor.sv
// Directed bench for water_flow_monitor with default parameters (16/2/3).
module tb_water_flow_monitor;

   logic       clk;
   logic       reset;
   logic       water_flow_reset;
   logic       water_flow_mode;
   logic [9:0] water_level_sensor;
   logic       water_flow_error;
   logic       monitor_active;
   logic [3:0] strike_count;

   int n_total = 0;
   int n_bad   = 0;

   water_flow_monitor dut (
      .clk                (clk),
      .reset              (reset),
      .water_flow_reset   (water_flow_reset),
      .water_flow_mode    (water_flow_mode),
      .water_level_sensor (water_level_sensor),
      .water_flow_error   (water_flow_error),
      .monitor_active     (monitor_active),
      .strike_count       (strike_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Idle for one edge, then arm at the next edge with the given mode/level.
   task automatic arm(input logic mode, input logic [9:0] level);
      water_flow_reset = 1'b1;
      step(1);
      water_flow_mode    = mode;
      water_level_sensor = level;
      water_flow_reset   = 1'b0;
      step(1);
   endtask

   initial begin
      int seen_err;
      int max_strike;

      reset              = 1'b0;
      water_flow_reset   = 1'b1;
      water_flow_mode    = 1'b1;
      water_level_sensor = 10'd100;
      #12;
      chk("rst_err", water_flow_error, 0);
      chk("rst_act", monitor_active, 0);
      chk("rst_strk", strike_count, 0);
      @(negedge clk);
      reset = 1'b1;
      step(2);
      chk("idle_act", monitor_active, 0);

      // Fill with good flow: +1 every 4 cycles gives +4 per window.
      arm(1'b1, 10'd100);
      chk("fill_arm_act", monitor_active, 1);
      seen_err = 0; max_strike = 0;
      for (int i = 0; i < 200; i++) begin
         if (i % 4 == 3) water_level_sensor = water_level_sensor + 10'd1;
         step(1);
         if (water_flow_error) seen_err = 1;
         if (strike_count > max_strike) max_strike = strike_count;
      end
      chk("fill_good_err", seen_err, 0);
      chk("fill_good_strk", max_strike, 0);

      // Fill stall at 100: strikes at +16, +32, fault exactly at +48.
      arm(1'b1, 10'd100);
      step(15);
      chk("stall_e15_strk", strike_count, 0);
      step(1);
      chk("stall_w1_strk", strike_count, 1);
      step(16);
      chk("stall_w2_strk", strike_count, 2);
      step(15);
      chk("stall_e47_err", water_flow_error, 0);
      step(1);
      chk("stall_e48_err", water_flow_error, 1);
      chk("stall_e48_strk", strike_count, 3);
      chk("stall_e48_act", monitor_active, 0);
      water_level_sensor = 10'd500;
      step(20);
      chk("fault_sticky_err", water_flow_error, 1);
      chk("fault_sticky_strk", strike_count, 3);

      // One-cycle clear pulse drops the fault, next edge re-arms.
      water_flow_reset = 1'b1;
      step(1);
      chk("clr_err", water_flow_error, 0);
      chk("clr_act", monitor_active, 0);
      chk("clr_strk", strike_count, 0);
      water_flow_reset = 1'b0;
      step(1);
      chk("rearm_act", monitor_active, 1);

      // Drain from 300, -5 per window down to 0, then held at 0.
      arm(1'b0, 10'd300);
      seen_err = 0; max_strike = 0;
      for (int w = 0; w < 64; w++) begin
         water_level_sensor = (water_level_sensor >= 10'd5) ? water_level_sensor - 10'd5 : 10'd0;
         step(16);
         if (water_flow_error) seen_err = 1;
         if (strike_count > max_strike) max_strike = strike_count;
      end
      chk("drain_good_err", seen_err, 0);
      chk("drain_good_strk", max_strike, 0);
      chk("drain_good_act", monitor_active, 1);

      // Drain with level rising 1 per window: fault at +48.
      arm(1'b0, 10'd300);
      water_level_sensor = 10'd301;
      step(16);
      chk("drain_up_w1", strike_count, 1);
      water_level_sensor = 10'd302;
      step(16);
      chk("drain_up_w2", strike_count, 2);
      water_level_sensor = 10'd303;
      step(15);
      chk("drain_up_e47", water_flow_error, 0);
      step(1);
      chk("drain_up_e48", water_flow_error, 1);

      // Recovery: two bad windows, one good, then three more bad to fault.
      arm(1'b1, 10'd200);
      step(32);
      chk("rec_two_bad", strike_count, 2);
      water_level_sensor = 10'd210;
      step(16);
      chk("rec_good", strike_count, 0);
      step(32);
      chk("rec_restall_strk", strike_count, 2);
      chk("rec_restall_err", water_flow_error, 0);
      step(16);
      chk("rec_restall_fault", water_flow_error, 1);

      // Mode flip seen at edge 31 clears strikes; fault 48 edges after flip.
      arm(1'b1, 10'd100);
      step(16);
      chk("flip_w1", strike_count, 1);
      step(14);
      water_flow_mode = 1'b0;
      step(1);
      chk("flip_strk", strike_count, 0);
      chk("flip_act", monitor_active, 1);
      step(47);
      chk("flip_e47_err", water_flow_error, 0);
      chk("flip_e47_strk", strike_count, 2);
      step(1);
      chk("flip_e48_err", water_flow_error, 1);

      // Mode change coinciding with an evaluation: window discarded.
      arm(1'b1, 10'd100);
      step(15);
      water_flow_mode = 1'b0;
      step(1);
      chk("flip_eval_strk", strike_count, 0);
      chk("flip_eval_act", monitor_active, 1);

      // Clear coinciding with the fault-causing evaluation: no fault.
      arm(1'b1, 10'd100);
      step(47);
      water_flow_reset = 1'b1;
      step(1);
      chk("clr_race_err", water_flow_error, 0);
      chk("clr_race_act", monitor_active, 0);
      chk("clr_race_strk", strike_count, 0);

      // Fill pinned at full scale is never a stall.
      arm(1'b1, 10'd1023);
      step(49);
      chk("full_err", water_flow_error, 0);
      chk("full_strk", strike_count, 0);

      // Asynchronous reset mid-window, no clock edge needed.
      arm(1'b1, 10'd100);
      step(20);
      chk("pre_async_strk", strike_count, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_err", water_flow_error, 0);
      chk("async_act", monitor_active, 0);
      chk("async_strk", strike_count, 0);
      @(negedge clk);
      reset = 1'b1;
      step(2);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
